// File: rtl/uart_tx_pkg.sv
// Shared types and constants for the SRAM-to-UART transmit path.
// The checksum state exists only when UART_TX_CHECKSUM_EN is defined.
package uart_tx_pkg;

    typedef enum logic [2:0] {
        S_TX_IDLE,
        S_TX_READ,
        S_TX_WAIT_DATA,
        S_TX_SEND_HIGH,
        S_TX_SEND_LOW,
`ifdef UART_TX_CHECKSUM_EN
        S_TX_CHECKSUM,
`endif
        S_TX_DONE
    } uart_tx_state_type;

    typedef enum logic [1:0] {
        S_SER_IDLE,
        S_SER_START,
        S_SER_DATA,
        S_SER_STOP
    } uart_ser_state_type;

    localparam int unsigned UART_FRAME_BITS = 10;

endpackage

// File: rtl/uart_tx_serializer.sv
// 8N1 byte serializer with a valid/ready handshake; ready is also raised in
// the final stop-bit cycle so consecutive frames follow with no idle gap.
module uart_tx_serializer
    import uart_tx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       byte_valid,
    input  logic [7:0] byte_data,
    output logic       byte_ready,
    output logic       tx
);

    localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [2:0] LAST_DATA_BIT = 3'(UART_FRAME_BITS - 3);

    uart_ser_state_type state;
    logic [CW-1:0]      baud_cnt;
    logic [7:0]         shift;
    logic [2:0]         bit_cnt;
    logic               bit_end;
    logic               xfer;

    assign bit_end    = (baud_cnt == CW'(CLKS_PER_BIT - 1));
    assign byte_ready = (state == S_SER_IDLE) || ((state == S_SER_STOP) && bit_end);
    assign xfer       = byte_valid && byte_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_SER_IDLE;
            baud_cnt <= '0;
            shift    <= '0;
            bit_cnt  <= '0;
            tx       <= 1'b1;
        end else begin
            case (state)
                S_SER_IDLE: begin
                    baud_cnt <= '0;
                    if (xfer) begin
                        shift <= byte_data;
                        tx    <= 1'b0;
                        state <= S_SER_START;
                    end
                end
                S_SER_START: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        tx       <= shift[0];
                        state    <= S_SER_DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                S_SER_DATA: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        if (bit_cnt == LAST_DATA_BIT) begin
                            tx    <= 1'b1;
                            state <= S_SER_STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            tx      <= shift[1];
                            shift   <= {1'b0, shift[7:1]};
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                S_SER_STOP: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        if (xfer) begin
                            shift <= byte_data;
                            tx    <= 1'b0;
                            state <= S_SER_START;
                        end else begin
                            state <= S_SER_IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: state <= S_SER_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_sram_tx_interface.sv
// Reads 16-bit SRAM words and sends each as two UART bytes, high byte first.
// Define UART_TX_CHECKSUM_EN to append an XOR checksum byte to each transfer.
module uart_sram_tx_interface
    import uart_tx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT      = 434,
    parameter int unsigned SRAM_READ_LATENCY = 2
) (
    input  logic        Clock,
    input  logic        Resetn,
    input  logic        Start,
    input  logic [17:0] Start_address,
    input  logic [17:0] Word_count,
    output logic [17:0] SRAM_address,
    input  logic [15:0] SRAM_read_data,
    output logic        SRAM_we_n,
    output logic        UART_TX_O,
    output logic        Busy,
    output logic        Done
);

    localparam int unsigned LW = (SRAM_READ_LATENCY > 0) ? $clog2(SRAM_READ_LATENCY + 1) : 1;

    uart_tx_state_type state;
    logic [17:0]       addr;
    logic [17:0]       rem_count;
    logic [LW-1:0]     wait_cnt;
    logic [15:0]       word_buf;
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              byte_ready;
    logic              xfer;
`ifdef UART_TX_CHECKSUM_EN
    logic [7:0]        checksum;
`endif

    assign SRAM_we_n = 1'b1;
    assign xfer      = byte_valid && byte_ready;

    always_comb begin
        byte_valid = 1'b0;
        byte_data  = word_buf[15:8];
        case (state)
            S_TX_SEND_HIGH: byte_valid = 1'b1;
            S_TX_SEND_LOW: begin
                byte_valid = 1'b1;
                byte_data  = word_buf[7:0];
            end
`ifdef UART_TX_CHECKSUM_EN
            S_TX_CHECKSUM: begin
                byte_valid = 1'b1;
                byte_data  = checksum;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state        <= S_TX_IDLE;
            addr         <= '0;
            rem_count    <= '0;
            wait_cnt     <= '0;
            word_buf     <= '0;
            SRAM_address <= '0;
            Busy         <= 1'b0;
            Done         <= 1'b0;
`ifdef UART_TX_CHECKSUM_EN
            checksum     <= '0;
`endif
        end else begin
            Done <= 1'b0;
            case (state)
                S_TX_IDLE: begin
                    if (Start) begin
                        addr      <= Start_address;
                        rem_count <= Word_count;
                        Busy      <= 1'b1;
`ifdef UART_TX_CHECKSUM_EN
                        checksum  <= '0;
                        state     <= (Word_count == '0) ? S_TX_CHECKSUM : S_TX_READ;
`else
                        state     <= (Word_count == '0) ? S_TX_DONE : S_TX_READ;
`endif
                    end
                end
                S_TX_READ: begin
                    SRAM_address <= addr;
                    wait_cnt     <= LW'(SRAM_READ_LATENCY);
                    state        <= S_TX_WAIT_DATA;
                end
                S_TX_WAIT_DATA: begin
                    if (wait_cnt == '0) begin
                        word_buf <= SRAM_read_data;
                        state    <= S_TX_SEND_HIGH;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                S_TX_SEND_HIGH: begin
                    if (xfer) begin
`ifdef UART_TX_CHECKSUM_EN
                        checksum <= checksum ^ byte_data;
`endif
                        state <= S_TX_SEND_LOW;
                    end
                end
                S_TX_SEND_LOW: begin
                    if (xfer) begin
                        rem_count <= rem_count - 1'b1;
                        addr      <= addr + 1'b1;
`ifdef UART_TX_CHECKSUM_EN
                        checksum  <= checksum ^ byte_data;
                        state     <= (rem_count == 18'd1) ? S_TX_CHECKSUM : S_TX_READ;
`else
                        state     <= (rem_count == 18'd1) ? S_TX_DONE : S_TX_READ;
`endif
                    end
                end
`ifdef UART_TX_CHECKSUM_EN
                S_TX_CHECKSUM: begin
                    if (xfer) state <= S_TX_DONE;
                end
`endif
                S_TX_DONE: begin
                    // ready here means idle or the last stop-bit cycle of the final frame
                    if (byte_ready) begin
                        Done  <= 1'b1;
                        Busy  <= 1'b0;
                        state <= S_TX_IDLE;
                    end
                end
                default: state <= S_TX_IDLE;
            endcase
        end
    end

    uart_tx_serializer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_serializer (
        .clk       (Clock),
        .rst_n     (Resetn),
        .byte_valid(byte_valid),
        .byte_data (byte_data),
        .byte_ready(byte_ready),
        .tx        (UART_TX_O)
    );

endmodule

// File: tb/tb_uart_sram_tx_interface.sv
// Directed, table-driven bench for uart_sram_tx_interface at 4 clocks per bit.
module tb_uart_sram_tx_interface;

    localparam int CPB   = 4;
    localparam int FRAME = 10 * CPB;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start = 1'b0;
    logic [17:0] start_addr = '0;
    logic [17:0] word_count = '0;
    logic [17:0] sram_addr;
    logic [15:0] sram_rdata;
    logic        we_n, tx, busy, done;

    always #5 clk = ~clk;

    uart_sram_tx_interface #(
        .CLKS_PER_BIT(CPB),
        .SRAM_READ_LATENCY(2)
    ) dut (
        .Clock(clk), .Resetn(rst_n), .Start(start),
        .Start_address(start_addr), .Word_count(word_count),
        .SRAM_address(sram_addr), .SRAM_read_data(sram_rdata),
        .SRAM_we_n(we_n), .UART_TX_O(tx), .Busy(busy), .Done(done)
    );

    // Two-stage SRAM read pipeline
    logic [15:0] mem [int];
    logic [15:0] d1;
    always @(posedge clk) begin
        d1         <= mem.exists(int'(sram_addr)) ? mem[int'(sram_addr)] : 16'h0;
        sram_rdata <= d1;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // UART receiver, sampling mid-bit on the falling clock edge
    logic [7:0] rx_q[$];
    int         rx_cyc[$];
    bit         rx_bad;
    bit         saw_rst;
    always @(negedge rst_n) saw_rst = 1'b1;

    initial begin : rx
        logic [7:0] b;
        int c;
        bit ok;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && tx === 1'b0) begin
                c = cyc; saw_rst = 1'b0; ok = 1'b1;
                repeat (2) @(negedge clk);
                if (tx !== 1'b0) ok = 1'b0;
                for (int k = 0; k < 8; k++) begin
                    repeat (CPB) @(negedge clk);
                    b[k] = tx;
                end
                repeat (CPB) @(negedge clk);
                if (tx !== 1'b1) ok = 1'b0;
                if (!saw_rst) begin
                    rx_q.push_back(b);
                    rx_cyc.push_back(c);
                    if (!ok) rx_bad = 1'b1;
                end
            end
        end
    end

    int   done_pulses;
    int   done_cyc;
    bit   done_long;
    logic done_prev = 1'b0;
    always @(negedge clk) begin
        if (done === 1'b1) begin
            done_pulses++;
            done_cyc = cyc;
            if (done_prev === 1'b1) done_long = 1'b1;
        end
        done_prev = done;
    end

    logic [17:0] addr_q[$];
    logic [17:0] last_addr = '0;
    always @(negedge clk) begin
        if (busy === 1'b1 && sram_addr !== last_addr) addr_q.push_back(sram_addr);
        last_addr = sram_addr;
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    function automatic logic [7:0] xor_bytes(input logic [63:0] v);
        logic [7:0] x = '0;
        for (int i = 0; i < 8; i++) x ^= v[8*i +: 8];
        return x;
    endfunction

    task automatic clear_logs();
        rx_q.delete(); rx_cyc.delete(); addr_q.delete();
        done_pulses = 0; done_long = 1'b0; rx_bad = 1'b0;
    endtask

    task automatic pulse_start(input logic [17:0] a, input logic [17:0] n);
        @(posedge clk); #1;
        start_addr = a; word_count = n; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin ok = 1'b1; break; end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s_timeout: got no Done, expected Done within 5000 cycles", name);
        end
        repeat (5) @(negedge clk);
    endtask

    task automatic check_bytes(input string name, input logic [63:0] exp_in, input int n_in);
        logic [63:0] exp = exp_in;
        logic [63:0] got = '0;
        int n = n_in;
`ifdef UART_TX_CHECKSUM_EN
        exp = {exp[55:0], xor_bytes(exp_in)};
        n++;
`endif
        foreach (rx_q[i]) got = {got[55:0], rx_q[i]};
        check({name, "_nbytes"}, rx_q.size(), n);
        check({name, "_bytes"}, got, exp);
    endtask

    task automatic check_frames(input string name);
        int n = rx_q.size();
        bit gap_ok = 1'b1;
        for (int i = 1; i < n; i++) if (rx_cyc[i] - rx_cyc[i-1] != FRAME) gap_ok = 1'b0;
        check({name, "_framing"}, {gap_ok, rx_bad}, 2'b10);
        check({name, "_done_once"}, {done_pulses, done_long}, {32'd1, 1'b0});
        if (n > 0) check({name, "_done_time"}, done_cyc - rx_cyc[0], FRAME * n);
    endtask

    typedef struct packed {
        logic [17:0] addr;
        logic [17:0] cnt;
        logic [47:0] words;
        logic [47:0] bytes;
    } vec_t;

    vec_t vecs[4];

    initial begin
        logic [63:0] ga, ea;
        bit bad;

        vecs[0] = '{addr: 18'h00100, cnt: 18'd1, words: 48'hA55A_0000_0000, bytes: 48'hA5_5A_00_00_00_00};
        vecs[1] = '{addr: 18'd262142, cnt: 18'd3, words: 48'h0102_0304_0506, bytes: 48'h01_02_03_04_05_06};
        vecs[2] = '{addr: 18'h00080, cnt: 18'd0, words: 48'h0, bytes: 48'h0};
        vecs[3] = '{addr: 18'h00200, cnt: 18'd2, words: 48'h1234_5678_0000, bytes: 48'h12_34_56_78_00_00};

        // Reset and idle
        rst_n = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_tx", tx, 1'b1);
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_we_n", we_n, 1'b1);
        check("reset_addr", sram_addr, 18'h0);
        bad = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || we_n !== 1'b1) bad = 1'b1;
        end
        check("reset_idle_hold", bad, 1'b0);

        // Table-driven transfers
        for (int v = 0; v < 4; v++) begin
            for (int i = 0; i < 3; i++)
                mem[int'(18'(vecs[v].addr + 18'(i)))] = vecs[v].words[47 - 16*i -: 16];
            clear_logs();
            pulse_start(vecs[v].addr, vecs[v].cnt);
            check($sformatf("v%0d_busy", v), busy, 1'b1);
            wait_done($sformatf("v%0d", v));
            check_bytes($sformatf("v%0d", v), 64'(vecs[v].bytes >> (48 - 16*int'(vecs[v].cnt))),
                        2 * int'(vecs[v].cnt));
            ga = '0; ea = '0;
            foreach (addr_q[i]) ga = (ga << 18) | 64'(addr_q[i]);
            for (int i = 0; i < int'(vecs[v].cnt); i++) ea = (ea << 18) | 64'(18'(vecs[v].addr + 18'(i)));
            check($sformatf("v%0d_naddr", v), addr_q.size(), vecs[v].cnt);
            check($sformatf("v%0d_addrs", v), ga, ea);
            check_frames($sformatf("v%0d", v));
            check($sformatf("v%0d_idle_after", v), {busy, tx}, 2'b01);
        end

        // Start while busy is ignored
        mem[32'h400] = 16'hDEAD; mem[32'h401] = 16'hBEEF; mem[32'h500] = 16'h7777;
        clear_logs();
        pulse_start(18'h400, 18'd2);
        repeat (10) @(negedge clk);
        pulse_start(18'h500, 18'd1);
        wait_done("busy_rej");
        check_bytes("busy_rej", 64'hDEAD_BEEF, 4);
        check("busy_rej_naddr", addr_q.size(), 2);
        if (addr_q.size() == 2) check("busy_rej_addrs", {addr_q[0], addr_q[1]}, {18'h400, 18'h401});
        check_frames("busy_rej");

        // Reset during the data bits of the second byte
        mem[32'h600] = 16'h1122; mem[32'h700] = 16'h3CC3;
        clear_logs();
        pulse_start(18'h600, 18'd1);
        bad = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (tx === 1'b0) begin bad = 1'b0; break; end
        end
        check("midrst_first_start", bad, 1'b0);
        repeat (FRAME + 14) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_tx", tx, 1'b1);
        check("midrst_busy", busy, 1'b0);
        check("midrst_first_byte", {rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 8'h0}, {32'd1, 8'h11});
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (60) @(negedge clk);
        check("midrst_quiet", {tx, busy}, 2'b10);
        clear_logs();
        pulse_start(18'h700, 18'd1);
        wait_done("midrst_new");
        check_bytes("midrst_new", 64'h3CC3, 2);
        check("midrst_new_addr", {addr_q.size(), (addr_q.size() > 0) ? addr_q[0] : 18'h0}, {32'd1, 18'h700});
        check_frames("midrst_new");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
